mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arbiter_if.sv | 36 +++
 rtl/rr_arb2.sv | 14 +
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared defaults and types for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int AW_DEF = 3;
  localparam int DW_DEF = 8;
  localparam int STAT_W = 16;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] wdata;
  } req_t;

  // Grant counters stick at all-ones instead of wrapping.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter; slave is the arbiter's view.
interface mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);
  logic          rq0_req,    rq1_req;
  logic          rq0_we,     rq1_we;
  logic [AW-1:0] rq0_addr,   rq1_addr;
  logic [DW-1:0] rq0_wdata,  rq1_wdata;
  logic          rq0_gnt,    rq1_gnt;
  logic          rq0_rvalid, rq1_rvalid;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata,
    input  mem_rdata,
    output rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rdata,
    output mem_addr, mem_wdata, mem_wr_en, mem_rd_en
  );

  modport master (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata,
    output mem_rdata,
    input  rq0_gnt, rq1_gnt, rq0_rvalid, rq1_rvalid, rdata,
    input  mem_addr, mem_wdata, mem_wr_en, mem_rd_en
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_gnt_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = req_i;
    if (&req_i) gnt_o = last_gnt_i ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter with one-cycle read return.
// Optional grant statistics when MEM_ARB_STATS_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] gnt_cnt0,
  output logic [STAT_W-1:0] gnt_cnt1
`endif
);

  logic [1:0]    req_v;
  logic [1:0]    gnt;
  logic          sel;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          last_gnt_q, last_gnt_d;
  logic          rd_pend_q,  rd_pend_d;
  logic          rd_owner_q, rd_owner_d;

  // Requests are masked during reset so nothing reaches the memory.
  assign req_v = reset ? 2'b00 : {bus.rq1_req, bus.rq0_req};

  rr_arb2 u_rr_arb2 (
    .req_i      (req_v),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (gnt)
  );

  assign sel       = gnt[1];
  assign sel_we    = sel ? bus.rq1_we    : bus.rq0_we;
  assign sel_addr  = sel ? bus.rq1_addr  : bus.rq0_addr;
  assign sel_wdata = sel ? bus.rq1_wdata : bus.rq0_wdata;

  always_comb begin
    bus.rq0_gnt    = gnt[0];
    bus.rq1_gnt    = gnt[1];
    bus.mem_addr   = sel_addr;
    bus.mem_wdata  = sel_wdata;
    bus.mem_wr_en  = (|gnt) &  sel_we;
    bus.mem_rd_en  = (|gnt) & ~sel_we;
    // Pending read is suppressed while reset is high, even before the flop clears.
    bus.rq0_rvalid = rd_pend_q & ~rd_owner_q & ~reset;
    bus.rq1_rvalid = rd_pend_q &  rd_owner_q & ~reset;
    bus.rdata      = (rd_pend_q & ~reset) ? bus.mem_rdata : '0;
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    rd_pend_d  = bus.mem_rd_en;
    rd_owner_d = rd_owner_q;
    if (|gnt) last_gnt_d = sel;
    if (bus.mem_rd_en) rd_owner_d = sel;
    if (reset) begin
      last_gnt_d = 1'b1;
      rd_pend_d  = 1'b0;
      rd_owner_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all flops update together.
    last_gnt_q <= last_gnt_d;
    rd_pend_q  <= rd_pend_d;
    rd_owner_q <= rd_owner_d;
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] cnt0_q, cnt0_d;
  logic [STAT_W-1:0] cnt1_q, cnt1_d;

  always_comb begin
    cnt0_d = gnt[0] ? sat_inc(cnt0_q) : cnt0_q;
    cnt1_d = gnt[1] ? sat_inc(cnt1_q) : cnt1_q;
    if (reset) begin
      cnt0_d = '0;
      cnt1_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    cnt0_q <= cnt0_d;
    cnt1_q <= cnt1_d;
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of grants, memory contents and read returns.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 3;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] gnt_cnt0, gnt_cnt1;
`endif

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef MEM_ARB_STATS_EN
    ,
    .gnt_cnt0 (gnt_cnt0),
    .gnt_cnt1 (gnt_cnt1)
`endif
  );

  // Memory device: untouched words read 0xCA, read data registered one cycle.
  logic [DW-1:0] mem [8] = '{default: 8'hCA};
  always @(posedge clk) begin
    if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [DW-1:0] ref_mem [8] = '{default: 8'hCA};
  int            last_winner;
  bit            pend_v;
  int            pend_owner;
  logic [DW-1:0] pend_data;

  task automatic idle();
    bus.rq0_req = 1'b0; bus.rq0_we = 1'b0; bus.rq0_addr = '0; bus.rq0_wdata = '0;
    bus.rq1_req = 1'b0; bus.rq1_we = 1'b0; bus.rq1_addr = '0; bus.rq1_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rq0_req = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 3'd3; bus.rq0_wdata = 8'h77;
    bus.rq1_req = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 3'd4;
    #1;
    n_checks++; if ({bus.rq0_gnt, bus.rq1_gnt} !== 2'b00) $display("FAIL rst_gnt: got %b want 00", {bus.rq0_gnt, bus.rq1_gnt}); else n_pass++;
    n_checks++; if ({bus.mem_wr_en, bus.mem_rd_en} !== 2'b00) $display("FAIL rst_en: got %b want 00", {bus.mem_wr_en, bus.mem_rd_en}); else n_pass++;
    step();
    n_checks++; if ({bus.rq0_rvalid, bus.rq1_rvalid} !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", {bus.rq0_rvalid, bus.rq1_rvalid}); else n_pass++;
    n_checks++; if (bus.rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", bus.rdata); else n_pass++;
    idle();
    reset = 1'b0;
    #1;
    n_checks++; if ({bus.rq0_rvalid, bus.rq1_rvalid} !== 2'b00) $display("FAIL rst_release_rvalid: got %b want 00", {bus.rq0_rvalid, bus.rq1_rvalid}); else n_pass++;
    step();
  endtask

  task automatic test_write_read();
    bus.rq0_req = 1'b1; bus.rq0_we = 1'b1; bus.rq0_addr = 3'd2; bus.rq0_wdata = 8'h5A;
    #1;
    n_checks++; if ({bus.rq0_gnt, bus.rq1_gnt} !== 2'b10) $display("FAIL wr_gnt: got %b want 10", {bus.rq0_gnt, bus.rq1_gnt}); else n_pass++;
    n_checks++; if ({bus.mem_wr_en, bus.mem_rd_en} !== 2'b10) $display("FAIL wr_en: got %b want 10", {bus.mem_wr_en, bus.mem_rd_en}); else n_pass++;
    n_checks++; if (bus.mem_addr !== 3'd2) $display("FAIL wr_addr: got %0d want 2", bus.mem_addr); else n_pass++;
    n_checks++; if (bus.mem_wdata !== 8'h5A) $display("FAIL wr_wdata: got %h want 5a", bus.mem_wdata); else n_pass++;
    ref_mem[2] = 8'h5A;
    step();
    idle();
    bus.rq1_req = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 3'd2;
    #1;
    n_checks++; if ({bus.rq0_rvalid, bus.rq1_rvalid} !== 2'b00) $display("FAIL wr_no_rvalid: got %b want 00", {bus.rq0_rvalid, bus.rq1_rvalid}); else n_pass++;
    n_checks++; if ({bus.rq0_gnt, bus.rq1_gnt} !== 2'b01) $display("FAIL rd_gnt: got %b want 01", {bus.rq0_gnt, bus.rq1_gnt}); else n_pass++;
    n_checks++; if ({bus.mem_wr_en, bus.mem_rd_en} !== 2'b01) $display("FAIL rd_en: got %b want 01", {bus.mem_wr_en, bus.mem_rd_en}); else n_pass++;
    n_checks++; if (bus.mem_addr !== 3'd2) $display("FAIL rd_addr: got %0d want 2", bus.mem_addr); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if ({bus.rq0_rvalid, bus.rq1_rvalid} !== 2'b01) $display("FAIL rd_rvalid: got %b want 01", {bus.rq0_rvalid, bus.rq1_rvalid}); else n_pass++;
    n_checks++; if (bus.rdata !== 8'h5A) $display("FAIL rd_rdata: got %h want 5a", bus.rdata); else n_pass++;
    step();
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        bus.rq0_req = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 3'd0;
        bus.rq1_req = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 3'd1;
      end else idle();
      #1;
      if (i < 4) begin
        n_checks++; if (bus.rq0_gnt !== (i % 2 == 0) || bus.rq1_gnt !== (i % 2 == 1)) $display("FAIL b2b_gnt[%0d]: got %b%b want rq%0d", i, bus.rq0_gnt, bus.rq1_gnt, i % 2); else n_pass++;
        n_checks++; if (bus.mem_rd_en !== 1'b1 || bus.mem_addr !== 3'(i % 2)) $display("FAIL b2b_mem[%0d]: got rd_en=%b addr=%0d want 1/%0d", i, bus.mem_rd_en, bus.mem_addr, i % 2); else n_pass++;
      end
      if (i > 0) begin
        n_checks++; if (bus.rq0_rvalid !== ((i - 1) % 2 == 0) || bus.rq1_rvalid !== ((i - 1) % 2 == 1)) $display("FAIL b2b_rvalid[%0d]: got %b%b want rq%0d", i, bus.rq0_rvalid, bus.rq1_rvalid, (i - 1) % 2); else n_pass++;
        n_checks++; if (bus.rdata !== 8'hCA) $display("FAIL b2b_rdata[%0d]: got %h want ca", i, bus.rdata); else n_pass++;
      end
      step();
    end
  endtask

  task automatic test_reset_mid_read();
    bus.rq0_req = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 3'd2;
    #1;
    n_checks++; if (bus.rq0_gnt !== 1'b1 || bus.mem_rd_en !== 1'b1) $display("FAIL mid_gnt: got gnt=%b rd_en=%b want 1/1", bus.rq0_gnt, bus.mem_rd_en); else n_pass++;
    step();
    idle();
    reset = 1'b1;
    #1;
    n_checks++; if ({bus.rq0_rvalid, bus.rq1_rvalid} !== 2'b00) $display("FAIL mid_rvalid_rst: got %b want 00", {bus.rq0_rvalid, bus.rq1_rvalid}); else n_pass++;
    step();
    reset = 1'b0;
    bus.rq0_req = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 3'd2;
    bus.rq1_req = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 3'd0;
    #1;
    n_checks++; if ({bus.rq0_rvalid, bus.rq1_rvalid} !== 2'b00) $display("FAIL mid_rvalid_post: got %b want 00", {bus.rq0_rvalid, bus.rq1_rvalid}); else n_pass++;
    n_checks++; if ({bus.rq0_gnt, bus.rq1_gnt} !== 2'b10) $display("FAIL mid_first_tie: got %b want 10", {bus.rq0_gnt, bus.rq1_gnt}); else n_pass++;
    step();
    bus.rq0_req = 1'b0;
    #1;
    n_checks++; if (bus.rq0_rvalid !== 1'b1 || bus.rdata !== 8'h5A) $display("FAIL mid_mem_kept: got rvalid=%b rdata=%h want 1/5a", bus.rq0_rvalid, bus.rdata); else n_pass++;
    n_checks++; if (bus.rq1_gnt !== 1'b1) $display("FAIL mid_rq1_gnt: got %b want 1", bus.rq1_gnt); else n_pass++;
    step();
    idle();
    #1;
    n_checks++; if (bus.rq1_rvalid !== 1'b1 || bus.rdata !== 8'hCA) $display("FAIL mid_rq1_data: got rvalid=%b rdata=%h want 1/ca", bus.rq1_rvalid, bus.rdata); else n_pass++;
    step();
  endtask

  task automatic test_no_starvation();
    int got = 0;
    bus.rq1_req = 1'b1; bus.rq1_we = 1'b0; bus.rq1_addr = 3'd5;
    for (int cyc = 1; cyc <= 4 && got == 0; cyc++) begin
      bus.rq0_req = 1'b1; bus.rq0_we = 1'b0; bus.rq0_addr = 3'(cyc);
      #1;
      if (bus.rq1_gnt === 1'b1) got = cyc;
      step();
    end
    n_checks++; if (got < 1 || got > 2) $display("FAIL starve: rq1 granted at cycle %0d want 1..2", got); else n_pass++;
    idle();
    step();
  endtask

  task automatic test_random();
    req_t r [2];
    int   exp_w;
    req_t win;
    pulse_reset();
    last_winner = 1;
    pend_v      = 1'b0;
    r[0] = '0;
    r[1] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!r[k].req && $urandom_range(0, 2) != 0) begin
          r[k].req   = 1'b1;
          r[k].we    = 1'($urandom_range(0, 1));
          r[k].addr  = 3'($urandom_range(0, 7));
          r[k].wdata = 8'($urandom);
        end
      end
      bus.rq0_req = r[0].req; bus.rq0_we = r[0].we; bus.rq0_addr = r[0].addr; bus.rq0_wdata = r[0].wdata;
      bus.rq1_req = r[1].req; bus.rq1_we = r[1].we; bus.rq1_addr = r[1].addr; bus.rq1_wdata = r[1].wdata;
      #1;
      if (r[0].req && r[1].req) exp_w = 1 - last_winner;
      else if (r[0].req)        exp_w = 0;
      else if (r[1].req)        exp_w = 1;
      else                      exp_w = -1;
      n_checks++; if (bus.rq0_gnt !== (exp_w == 0) || bus.rq1_gnt !== (exp_w == 1)) $display("FAIL rnd_gnt[%0d]: got %b%b want winner %0d", c, bus.rq0_gnt, bus.rq1_gnt, exp_w); else n_pass++;
      n_checks++; if (bus.rq0_rvalid !== (pend_v && pend_owner == 0) || bus.rq1_rvalid !== (pend_v && pend_owner == 1)) $display("FAIL rnd_rvalid[%0d]: got %b%b want pend=%0d owner=%0d", c, bus.rq0_rvalid, bus.rq1_rvalid, pend_v, pend_owner); else n_pass++;
      if (pend_v) begin
        n_checks++; if (bus.rdata !== pend_data) $display("FAIL rnd_rdata[%0d]: got %h want %h", c, bus.rdata, pend_data); else n_pass++;
      end
      if (exp_w >= 0) begin
        win = r[exp_w];
        n_checks++; if (bus.mem_wr_en !== win.we || bus.mem_rd_en !== !win.we || bus.mem_addr !== win.addr) $display("FAIL rnd_mem[%0d]: got wr=%b rd=%b addr=%0d want wr=%b addr=%0d", c, bus.mem_wr_en, bus.mem_rd_en, bus.mem_addr, win.we, win.addr); else n_pass++;
        if (win.we) begin
          n_checks++; if (bus.mem_wdata !== win.wdata) $display("FAIL rnd_wdata[%0d]: got %h want %h", c, bus.mem_wdata, win.wdata); else n_pass++;
        end
        pend_v      = !win.we;
        pend_owner  = exp_w;
        pend_data   = ref_mem[win.addr];
        if (win.we) ref_mem[win.addr] = win.wdata;
        last_winner = exp_w;
        r[exp_w].req = 1'b0;
      end else begin
        n_checks++; if ({bus.mem_wr_en, bus.mem_rd_en} !== 2'b00) $display("FAIL rnd_idle_en[%0d]: got %b want 00", c, {bus.mem_wr_en, bus.mem_rd_en}); else n_pass++;
        pend_v = 1'b0;
      end
      step();
    end
    idle();
    #1;
    n_checks++; if (bus.rq0_rvalid !== (pend_v && pend_owner == 0) || bus.rq1_rvalid !== (pend_v && pend_owner == 1)) $display("FAIL rnd_tail_rvalid: got %b%b want pend=%0d owner=%0d", bus.rq0_rvalid, bus.rq1_rvalid, pend_v, pend_owner); else n_pass++;
    if (pend_v) begin
      n_checks++; if (bus.rdata !== pend_data) $display("FAIL rnd_tail_rdata: got %h want %h", bus.rdata, pend_data); else n_pass++;
    end
    step();
  endtask

`ifdef MEM_ARB_STATS_EN
  task automatic test_stats();
    pulse_reset();
    #1;
    n_checks++; if (gnt_cnt0 !== 16'd0 || gnt_cnt1 !== 16'd0) $display("FAIL stats_rst: got %0d/%0d want 0/0", gnt_cnt0, gnt_cnt1); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      idle();
      if (i < 5) begin bus.rq0_req = 1'b1; bus.rq0_addr = 3'd4; end
      else       begin bus.rq1_req = 1'b1; bus.rq1_addr = 3'd5; end
      step();
    end
    idle();
    #1;
    n_checks++; if (gnt_cnt0 !== 16'd5 || gnt_cnt1 !== 16'd3) $display("FAIL stats_count: got %0d/%0d want 5/3", gnt_cnt0, gnt_cnt1); else n_pass++;
    bus.rq0_req = 1'b1; bus.rq0_addr = 3'd4;
    for (int i = 0; i < 65535; i++) step();
    idle();
    #1;
    n_checks++; if (gnt_cnt0 !== 16'hFFFF || gnt_cnt1 !== 16'd3) $display("FAIL stats_sat: got %h/%0d want ffff/3", gnt_cnt0, gnt_cnt1); else n_pass++;
    step();
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_reset_mid_read();
    test_no_starvation();
    test_random();
`ifdef MEM_ARB_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
